ahbl_sram_excl: RTL and testbench
=================================

Name: ahbl_sram_excl

Overview:
- AHB-Lite responder (slave end) sitting behind an N:1 arbiter port.
- Provides a word-organised on-chip SRAM with a programmable number of wait states and AHB error responses.
- Includes an exclusive-access monitor driving hexokay from hexcl/hmaster, so the harts' LR/SC and AMO sequences can target it.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width (fixed 32; byte lanes 4).
- DEPTH, 1024, memory depth in words; power of two.
- WAIT_STATES, 0, extra data-phase cycles per transfer (0..15).
- N_MASTERS, 4, number of reservation slots, indexed by hmaster[$clog2(N_MASTERS)-1:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- ahbls_hready  in  1  bus HREADY (address phase qualifier)
- ahbls_hready_resp  out  1  slave HREADYOUT
- ahbls_hresp  out  1  error response
- ahbls_haddr  in  W_ADDR  address
- ahbls_hwrite  in  1  write
- ahbls_htrans  in  2  transfer type
- ahbls_hsize  in  3  size
- ahbls_hburst  in  3  ignored
- ahbls_hprot  in  4  ignored
- ahbls_hmastlock  in  1  ignored
- ahbls_hwdata  in  W_DATA  write data (data phase)
- ahbls_hrdata  out  W_DATA  read data
- ahbls_hexcl  in  1  exclusive transfer
- ahbls_hmaster  in  8  master ID
- ahbls_hexokay  out  1  exclusive success

Behaviour:
- Reset (rst=1 at posedge):
  - hready_resp=1, hresp=0, hexokay=0, hrdata=0.
  - State IDLE, all reservations invalid.
  - Memory contents are not reset.
- Address phase accepted when hready & htrans[1]. Capture addr, write, size, excl, master index.
- Error check: hsize>2, misaligned (halfword addr[0]!=0, word addr[1:0]!=0), or word index >= DEPTH.
- Lane mask from hsize and addr[1:0]: byte = 1 lane; halfword = lanes {1:0} or {3:2}; word = all.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, transfer accepted, legal: go to WAIT with counter = WAIT_STATES. If WAIT_STATES==0, the data phase completes in one cycle (hready_resp=1 during it).
  - IDLE, transfer accepted, illegal: go to ERR1.
  - WAIT: hready_resp=0 while counter!=0; decrement each cycle. On the cycle counter==0, hready_resp=1 and the transfer completes. A new address phase may be accepted on that completing cycle (pipelined back-to-back, no bubble).
  - ERR1: hready_resp=0, hresp=1. ERR2: hready_resp=1, hresp=1. After ERR2, accept a new address phase as from IDLE. No memory access and no reservation change on error.
- Reads:
  - hrdata is valid in the completing cycle and is 0 in non-completing cycles.
  - Full word returned regardless of size.
  - A read whose address phase coincides with the completing data phase of a write to the same word returns the merged new data (byte forwarding).
- Writes: hwdata sampled on the completing cycle; only masked lanes are written.
- Exclusive monitor: reservation per master slot = {valid, word index}.
  - Exclusive read completes: set slot valid with that word index. Overwrites any earlier reservation in that slot.
  - Exclusive write, slot valid and index matches: write performed, hexokay=1 in the completing cycle, slot cleared.
  - Exclusive write, otherwise: write suppressed, hexokay=0, hresp=0 (OKAY), slot cleared.
  - Any performed write (normal or successful exclusive) clears every slot holding the same word index, including other masters' slots.
  - Exclusive read: hexokay=1 in the completing cycle (monitor supports exclusives).
  - Non-exclusive transfers: hexokay=0.
  - hmaster index >= N_MASTERS: exclusive writes always fail and exclusive reads set no reservation.
- Simultaneous events on the same edge: the write-clear is applied before the new exclusive-read set, so a read of the same word re-establishes its reservation.
- htrans IDLE/BUSY accepted with hready: zero-wait OKAY, no side effects.
- Reset mid-transfer: abandons the transfer, returns to the reset values above, and performs no memory write.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back → hready_resp never low; hrdata=0xDEADBEEF on read completion (forwarded).
- WAIT_STATES=2: read of 0x0 → hready_resp low for 2 cycles then high. Byte write 0xAA to 0x3 over 0x11223344 → readback 0xAA223344.
- Illegal word access at 0x2 → ERR1 (ready 0, resp 1), then ERR2 (ready 1, resp 1); memory unchanged.
- Out-of-range access at DEPTH*4 → two-cycle error.
- Master 1: excl read 0x40, then excl write 0x5 → hexokay=1 and the word becomes 0x5. A repeat excl write of 0x6 → hexokay=0 and the word stays 0x5.
- Master 1 excl read 0x40; master 2 normal write 0x9 to 0x40; master 1 excl write 0x7 → hexokay=0, word=0x9.
- Assert rst in WAIT (WAIT_STATES=3) during a write → hready_resp=1 next cycle, target word unchanged, reservations cleared.

Source files
------------

// File: rtl/ahbl_sram_excl.sv
// AHB-Lite SRAM responder with programmable wait states, error responses and
// an exclusive-access monitor (one reservation slot per master index).
module ahbl_sram_excl #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int N_MASTERS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,
    input  logic              ahbls_hexcl,
    input  logic [7:0]        ahbls_hmaster,
    output logic              ahbls_hexokay
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SLOT_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [W_DATA-1:0] merge_lanes(input logic [W_DATA-1:0] old_w,
                                                      input logic [W_DATA-1:0] new_w,
                                                      input logic [3:0]        mask);
        for (int i = 0; i < 4; i++)
            merge_lanes[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    endfunction

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic [W_DATA-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx_p1;
    logic [3:0]        lanes_p1;
    logic              write_p1, excl_p1, mok_p1;
    logic [SLOT_W-1:0] slot_p1;
    logic [W_DATA-1:0] rd_p1;

    logic [N_MASTERS-1:0] res_valid, res_valid_n;
    logic [IDX_W-1:0]     res_idx   [N_MASTERS];
    logic [IDX_W-1:0]     res_idx_n [N_MASTERS];

    logic              req, can_accept, accept, illegal, complete;
    logic              excl_ok, wr_en, fwd, a_mok;
    logic [IDX_W-1:0]  a_idx;
    logic [SLOT_W-1:0] a_slot;

    logic unused_ok;
    assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

    // Address-phase decode
    assign req        = ahbls_hready & ahbls_htrans[1];
    assign complete   = (state == S_WAIT) && (cnt == 4'd0);
    assign can_accept = (state == S_IDLE) || (state == S_ERR2) || complete;
    assign accept     = req & can_accept;
    assign a_idx      = ahbls_haddr[IDX_W+1:2];
    assign a_slot     = ahbls_hmaster[SLOT_W-1:0];
    assign a_mok      = {1'b0, ahbls_hmaster} < 9'(N_MASTERS);
    assign illegal    = (ahbls_hsize > 3'd2)
                     || ((ahbls_hsize == 3'd1) && ahbls_haddr[0])
                     || ((ahbls_hsize == 3'd2) && (ahbls_haddr[1:0] != 2'b00))
                     || (ahbls_haddr[W_ADDR-1:2] >= (W_ADDR-2)'(DEPTH));

    // Data-phase resolution
    assign excl_ok = excl_p1 & write_p1 & mok_p1 & res_valid[slot_p1]
                   & (res_idx[slot_p1] == idx_p1);
    assign wr_en   = complete & write_p1 & (~excl_p1 | excl_ok);
    assign fwd     = wr_en & (a_idx == idx_p1);

    assign ahbls_hrdata  = (complete && !write_p1) ? rd_p1 : '0;
    assign ahbls_hexokay = complete & excl_p1 & (write_p1 ? excl_ok : 1'b1);

    always_comb begin
        state_n           = state;
        cnt_n             = cnt;
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        case (state)
            S_IDLE: state_n = S_IDLE;
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    ahbls_hready_resp = 1'b0;
                    cnt_n             = cnt - 4'd1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
                state_n           = S_ERR2;
            end
            S_ERR2: begin
                ahbls_hresp = 1'b1;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) begin
            state_n = illegal ? S_ERR1 : S_WAIT;
            cnt_n   = 4'(WAIT_STATES);
        end
    end

    // Write-clear first, then the exclusive-read set, so a same-edge set wins
    always_comb begin
        res_valid_n = res_valid;
        res_idx_n   = res_idx;
        if (complete) begin
            for (int i = 0; i < N_MASTERS; i++)
                if (wr_en && res_valid[i] && (res_idx[i] == idx_p1))
                    res_valid_n[i] = 1'b0;
            if (excl_p1 && mok_p1) begin
                if (write_p1) begin
                    res_valid_n[slot_p1] = 1'b0;
                end else begin
                    res_valid_n[slot_p1] = 1'b1;
                    res_idx_n[slot_p1]   = idx_p1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            res_valid <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            res_valid <= res_valid_n;
        end
    end

    always_ff @(posedge clk) begin
        res_idx <= res_idx_n;
        if (accept) begin
            idx_p1   <= a_idx;
            lanes_p1 <= lane_mask(ahbls_hsize, ahbls_haddr[1:0]);
            write_p1 <= ahbls_hwrite;
            excl_p1  <= ahbls_hexcl;
            mok_p1   <= a_mok;
            slot_p1  <= a_slot;
            rd_p1    <= fwd ? merge_lanes(mem[a_idx], ahbls_hwdata, lanes_p1) : mem[a_idx];
        end
    end

    // A reset landing on the completing edge abandons the write
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            for (int i = 0; i < 4; i++)
                if (lanes_p1[i])
                    mem[idx_p1][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Directed bench: three responders (0, 2 and 3 wait states) driven independently,
// each with its HREADY fed back from its own HREADYOUT.
module tb_ahbl_sram_excl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] haddr   [3];
    logic        hwrite  [3];
    logic [1:0]  htrans  [3];
    logic [2:0]  hsize   [3];
    logic        hexcl   [3];
    logic [7:0]  hmaster [3];
    logic [31:0] hwdata  [3];
    logic        hready  [3];
    logic        hresp   [3];
    logic        hexokay [3];
    logic [31:0] hrdata  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahbl_sram_excl #(
            .W_ADDR(32), .W_DATA(32), .DEPTH(1024),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3)), .N_MASTERS(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .ahbls_hready(hready[g]), .ahbls_hready_resp(hready[g]),
            .ahbls_hresp(hresp[g]), .ahbls_haddr(haddr[g]),
            .ahbls_hwrite(hwrite[g]), .ahbls_htrans(htrans[g]),
            .ahbls_hsize(hsize[g]), .ahbls_hburst(3'b000),
            .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
            .ahbls_hwdata(hwdata[g]), .ahbls_hrdata(hrdata[g]),
            .ahbls_hexcl(hexcl[g]), .ahbls_hmaster(hmaster[g]),
            .ahbls_hexokay(hexokay[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Results of the most recent transfer
    logic [31:0] r_data, r_data_low;
    logic        r_resp, r_xok, r_resp_low;
    int          r_lows;

    // Non-pipelined transfer; called and returns at posedge+1
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic ex, input logic [7:0] m,
                        input logic [31:0] wd);
        bit got = 0;
        haddr[d] = addr; hwrite[d] = wr; hsize[d] = size; hexcl[d] = ex;
        hmaster[d] = m; htrans[d] = 2'b10;
        @(posedge clk); #1;
        htrans[d] = 2'b00; hwdata[d] = wd;
        r_lows = 0; r_resp_low = 1'b0; r_data_low = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hready[d]) begin
                got = 1; r_data = hrdata[d]; r_resp = hresp[d]; r_xok = hexokay[d];
                break;
            end
            r_lows++; r_resp_low = hresp[d]; r_data_low |= hrdata[d];
        end
        if (!got) check("xfer_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            haddr[d] = '0; hwrite[d] = 0; htrans[d] = 2'b00; hsize[d] = 3'd2;
            hexcl[d] = 0; hmaster[d] = 8'd0; hwdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(hready[d]), 32'd1);
            check("rst_resp",  32'(hresp[d]), 32'd0);
            check("rst_xok",   32'(hexokay[d]), 32'd0);
            check("rst_rdata", hrdata[d], 32'd0);
        end
        @(posedge clk); #1;

        // Zero wait states: write then read of the same word back-to-back
        haddr[0] = 32'h10; hwrite[0] = 1; hsize[0] = 3'd2; htrans[0] = 2'b10;
        @(posedge clk); #1;
        hwrite[0] = 0; hwdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        check("ws0_wr_ready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        check("ws0_rd_ready", 32'(hready[0]), 32'd1);
        check("ws0_fwd_data", hrdata[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        xfer(0, 32'h10, 0, 3'd2, 0, 8'd0, 0);
        check("ws0_readback", r_data, 32'hDEADBEEF);
        check("ws0_lows", 32'(r_lows), 32'd0);

        // Two wait states, sub-word writes
        xfer(1, 32'h0, 1, 3'd2, 0, 8'd0, 32'h11223344);
        check("ws2_wr_lows", 32'(r_lows), 32'd2);
        xfer(1, 32'h0, 0, 3'd2, 0, 8'd0, 0);
        check("ws2_rd_lows", 32'(r_lows), 32'd2);
        check("ws2_rd_data", r_data, 32'h11223344);
        check("ws2_rd_zero_while_wait", r_data_low, 32'd0);
        xfer(1, 32'h3, 1, 3'd0, 0, 8'd0, 32'hAA5A5A5A);
        xfer(1, 32'h0, 0, 3'd2, 0, 8'd0, 0);
        check("byte_write", r_data, 32'hAA223344);
        xfer(1, 32'h0, 1, 3'd1, 0, 8'd0, 32'h55667788);
        xfer(1, 32'h1, 0, 3'd0, 0, 8'd0, 0);
        check("half_write", r_data, 32'hAA227788);

        // Error responses
        xfer(1, 32'h2, 1, 3'd2, 0, 8'd0, 32'hFFFFFFFF);
        check("mis_err1_lows", 32'(r_lows), 32'd1);
        check("mis_err1_resp", 32'(r_resp_low), 32'd1);
        check("mis_err2_resp", 32'(r_resp), 32'd1);
        xfer(1, 32'h1000, 1, 3'd2, 0, 8'd0, 32'hFFFFFFFF);
        check("oor_lows", 32'(r_lows), 32'd1);
        check("oor_resp", 32'(r_resp), 32'd1);
        xfer(1, 32'h1, 1, 3'd1, 0, 8'd0, 32'hFFFFFFFF);
        check("half_mis_resp", 32'(r_resp), 32'd1);
        xfer(1, 32'h0, 1, 3'd3, 0, 8'd0, 32'hFFFFFFFF);
        check("size3_resp", 32'(r_resp), 32'd1);
        xfer(1, 32'h0, 0, 3'd2, 0, 8'd0, 0);
        check("err_mem_unchanged", r_data, 32'hAA227788);
        check("ok_resp", 32'(r_resp), 32'd0);

        // Exclusive pair from master 1
        xfer(1, 32'h40, 1, 3'd2, 0, 8'd1, 32'h0);
        xfer(1, 32'h40, 0, 3'd2, 1, 8'd1, 0);
        check("exrd_xok", 32'(r_xok), 32'd1);
        xfer(1, 32'h40, 1, 3'd2, 1, 8'd1, 32'h5);
        check("exwr_ok", 32'(r_xok), 32'd1);
        xfer(1, 32'h40, 0, 3'd2, 0, 8'd1, 0);
        check("exwr_data", r_data, 32'h5);
        check("normal_rd_xok", 32'(r_xok), 32'd0);
        xfer(1, 32'h40, 1, 3'd2, 1, 8'd1, 32'h6);
        check("exwr_repeat_xok", 32'(r_xok), 32'd0);
        check("exwr_repeat_resp", 32'(r_resp), 32'd0);
        xfer(1, 32'h40, 0, 3'd2, 0, 8'd1, 0);
        check("exwr_repeat_data", r_data, 32'h5);

        // Another master's write breaks the reservation
        xfer(1, 32'h40, 0, 3'd2, 1, 8'd1, 0);
        xfer(1, 32'h40, 1, 3'd2, 0, 8'd2, 32'h9);
        xfer(1, 32'h40, 1, 3'd2, 1, 8'd1, 32'h7);
        check("stolen_xok", 32'(r_xok), 32'd0);
        xfer(1, 32'h40, 0, 3'd2, 0, 8'd1, 0);
        check("stolen_data", r_data, 32'h9);

        // Reset in the middle of a three-wait-state write
        xfer(2, 32'h80, 1, 3'd2, 0, 8'd0, 32'h12345678);
        check("ws3_lows", 32'(r_lows), 32'd3);
        xfer(2, 32'h80, 0, 3'd2, 1, 8'd0, 0);
        check("ws3_exrd", r_data, 32'h12345678);
        haddr[2] = 32'h80; hwrite[2] = 1; hsize[2] = 3'd2; hexcl[2] = 0; htrans[2] = 2'b10;
        @(posedge clk); #1;
        htrans[2] = 2'b00; hwdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(hready[2]), 32'd1);
        check("midrst_resp", 32'(hresp[2]), 32'd0);
        @(posedge clk); #1;
        xfer(2, 32'h80, 0, 3'd2, 0, 8'd0, 0);
        check("midrst_mem", r_data, 32'h12345678);
        xfer(2, 32'h80, 1, 3'd2, 1, 8'd0, 32'hBADBAD00);
        check("midrst_res_cleared", 32'(r_xok), 32'd0);
        xfer(2, 32'h80, 0, 3'd2, 0, 8'd0, 0);
        check("midrst_exwr_suppressed", r_data, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
